// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional skid buffer for valid/ready handshaking.
// Define PIPE_SKID_BUF_EN for the two-entry (skid) variant; default is a single-entry stage.
module pipe_skid_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int OP_W    = 6,
  parameter int NOP_OP  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bubble,
  input  logic [DATA_W-1:0]  in_rd_data,
  input  logic [DATA_W-1:0]  in_mem_addr,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic [OP_W-1:0]    in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_rd_data,
  output logic [DATA_W-1:0]  out_mem_addr,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic [OP_W-1:0]    out_op,
  output logic [1:0]         occupancy
);

  localparam int ENTRY_W = 2 * DATA_W + RADDR_W + OP_W;
  localparam logic [OP_W-1:0] NOP = OP_W'(NOP_OP);
  localparam logic [ENTRY_W-1:0] RESET_ENTRY = {{(ENTRY_W - OP_W){1'b0}}, NOP};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [ENTRY_W-1:0] out_reg;
  logic [ENTRY_W-1:0] in_entry;
  logic               active;
  logic               accept;
  logic               pop;
  logic               load_out;

  assign active    = rdy & ~rst;
  assign out_valid = active & (state_reg != EMPTY);
  assign pop       = out_valid & out_ready;
  assign accept    = in_valid & in_ready;
  assign in_entry  = {in_rd_data, in_mem_addr, in_rd_addr, (in_bubble ? NOP : in_op)};

`ifdef PIPE_SKID_BUF_EN
  logic [ENTRY_W-1:0] skid_reg;
  logic               in_ready_reg;
  logic               load_skid;
  logic               skid_to_out;

  // Registered ready: depends only on held state, never on out_ready.
  assign in_ready = active & in_ready_reg;
`else
  assign in_ready = active & ((state_reg == EMPTY) | out_ready);
`endif

  always_comb begin
    state_next  = state_reg;
    load_out    = 1'b0;
`ifdef PIPE_SKID_BUF_EN
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
`endif
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          load_out   = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && pop) load_out = 1'b1;
`ifdef PIPE_SKID_BUF_EN
        else if (accept) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end
`endif
        else if (pop) state_next = EMPTY;
      end
`ifdef PIPE_SKID_BUF_EN
      FULL: begin
        if (pop) begin
          skid_to_out = 1'b1;
          state_next  = ONE;
        end
      end
`endif
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      out_reg      <= RESET_ENTRY;
`ifdef PIPE_SKID_BUF_EN
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
`endif
    end else if (rdy) begin
      if (flush) begin
        state_reg    <= EMPTY;
        out_reg      <= RESET_ENTRY;
`ifdef PIPE_SKID_BUF_EN
        skid_reg     <= '0;
        in_ready_reg <= 1'b1;
`endif
      end else begin
        state_reg <= state_next;
        if (load_out) out_reg <= in_entry;
`ifdef PIPE_SKID_BUF_EN
        else if (skid_to_out) out_reg <= skid_reg;
        if (load_skid) skid_reg <= in_entry;
        in_ready_reg <= (state_next != FULL);
`endif
      end
    end
  end

  assign out_op       = out_reg[OP_W-1:0];
  assign out_rd_addr  = out_reg[OP_W +: RADDR_W];
  assign out_mem_addr = out_reg[OP_W + RADDR_W +: DATA_W];
  assign out_rd_data  = out_reg[OP_W + RADDR_W + DATA_W +: DATA_W];
  assign occupancy    = state_reg;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector table plus a randomized
// handshake stress against a queue model. Expectations follow PIPE_SKID_BUF_EN.
module tb_pipe_skid_reg;

`ifdef PIPE_SKID_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, flush, in_valid, in_ready, in_bubble;
  logic [31:0] in_rd_data, in_mem_addr;
  logic [4:0]  in_rd_addr;
  logic [5:0]  in_op;
  logic        out_valid, out_ready;
  logic [31:0] out_rd_data, out_mem_addr;
  logic [4:0]  out_rd_addr;
  logic [5:0]  out_op;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_bubble(in_bubble),
    .in_rd_data(in_rd_data), .in_mem_addr(in_mem_addr), .in_rd_addr(in_rd_addr), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_data(out_rd_data), .out_mem_addr(out_mem_addr), .out_rd_addr(out_rd_addr),
    .out_op(out_op), .occupancy(occupancy)
  );

  typedef struct {
    logic        rdy, rst, flush, iv, bub, ordy;
    logic [5:0]  op;
    logic [31:0] data;
    logic        chk, chk_d, e_ir, e_ov;
    logic [5:0]  e_op;
    logic [31:0] e_data;
    logic [1:0]  e_occ;
  } vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] data;
  } entry_t;

  vec_t   vecs[$];
  entry_t model_q[$];

  task automatic add(input logic r, input logic rs, input logic f, input logic iv,
                     input logic b, input logic o, input logic [5:0] op, input logic [31:0] d,
                     input logic c, input logic cd, input logic eir, input logic eov,
                     input logic [5:0] eop, input logic [31:0] ed, input logic [1:0] eocc);
    vec_t v;
    v.rdy = r; v.rst = rs; v.flush = f; v.iv = iv; v.bub = b; v.ordy = o;
    v.op = op; v.data = d; v.chk = c; v.chk_d = cd; v.e_ir = eir; v.e_ov = eov;
    v.e_op = eop; v.e_data = ed; v.e_occ = eocc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Payload fields are derived from rd_data so a single expected value covers all of them.
  task automatic drive(input logic [5:0] op, input logic [31:0] d);
    in_op       = op;
    in_rd_data  = d;
    in_mem_addr = d * 3;
    in_rd_addr  = d[4:0];
  endtask

  task automatic check_payload(input string tag, input logic [5:0] eop, input logic [31:0] ed);
    logic [31:0] ma;
    ma = ed * 3;
    check({tag, "_op"}, 32'(out_op), 32'(eop));
    check({tag, "_rd_data"}, out_rd_data, ed);
    check({tag, "_mem_addr"}, out_mem_addr, ma);
    check({tag, "_rd_addr"}, 32'(out_rd_addr), 32'(ed[4:0]));
  endtask

  initial begin
    entry_t e;
    logic   exp_ir, exp_ov;

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; in_bubble = 1'b0; out_ready = 1'b0;
    drive(6'd0, 32'd0);

    // Reset and first cycle after reset.
    add(1,1,0,0,0,0, 0,0,        0,0,0,0,0,0,0);
    add(1,1,0,0,0,0, 0,0,        1,1,0,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,        1,1,1,0,0,0,0);
    // Streaming at full rate: latency 1, occupancy 1.
    add(1,0,0,1,0,1, 1,'h10,     1,0,1,0,0,0,0);
    add(1,0,0,1,0,1, 2,'h11,     1,0,1,1,1,'h10,1);
    add(1,0,0,1,0,1, 3,'h12,     1,0,1,1,2,'h11,1);
    add(1,0,0,1,0,1, 4,'h13,     1,0,1,1,3,'h12,1);
    add(1,0,0,0,0,1, 0,0,        1,0,1,1,4,'h13,1);
    add(1,0,0,0,0,1, 0,0,        1,0,1,0,0,0,0);
    // Bubble replaces the opcode only.
    add(1,0,0,1,1,0, 5,'hDEAD,   1,0,1,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,        1,0,BUF,1,0,'hDEAD,1);
    add(1,0,0,0,0,1, 0,0,        1,0,1,1,0,'hDEAD,1);
    add(1,0,0,0,0,1, 0,0,        1,0,1,0,0,0,0);
`ifdef PIPE_SKID_BUF_EN
    // Backpressure fills the skid, third entry waits upstream.
    add(1,0,0,1,0,0, 1,'h21,     1,0,1,0,0,0,0);
    add(1,0,0,1,0,0, 2,'h22,     1,0,1,1,1,'h21,1);
    add(1,0,0,1,0,0, 3,'h23,     1,0,0,1,1,'h21,2);
    add(1,0,0,1,0,1, 3,'h23,     1,0,0,1,1,'h21,2);
    add(1,0,0,1,0,1, 3,'h23,     1,0,1,1,2,'h22,1);
    add(1,0,0,0,0,1, 0,0,        1,0,1,1,3,'h23,1);
    add(1,0,0,0,0,1, 0,0,        1,0,1,0,0,0,0);
    // rdy=0 freezes FULL (flush also ignored), then pops resume.
    add(1,0,0,1,0,0, 1,'h31,     1,0,1,0,0,0,0);
    add(1,0,0,1,0,0, 2,'h32,     1,0,1,1,1,'h31,1);
    add(0,0,0,1,0,1, 3,'h33,     1,1,0,0,1,'h31,2);
    add(0,0,0,1,0,1, 3,'h33,     1,1,0,0,1,'h31,2);
    add(0,0,1,1,0,1, 3,'h33,     1,1,0,0,1,'h31,2);
    add(1,0,0,0,0,1, 0,0,        1,0,0,1,1,'h31,2);
    add(1,0,0,0,0,1, 0,0,        1,0,1,1,2,'h32,1);
    add(1,0,0,0,0,1, 0,0,        1,0,1,0,0,0,0);
    // Flush from FULL drops both held entries and the offered one.
    add(1,0,0,1,0,0, 1,'h41,     1,0,1,0,0,0,0);
    add(1,0,0,1,0,0, 2,'h42,     1,0,1,1,1,'h41,1);
    add(1,0,1,1,0,1, 3,'h43,     1,0,0,1,1,'h41,2);
    add(1,0,0,0,0,1, 0,0,        1,1,1,0,0,0,0);
    add(1,0,0,0,0,1, 0,0,        1,0,1,0,0,0,0);
`else
    // Backpressure: single entry, in_ready follows out_ready.
    add(1,0,0,1,0,0, 1,'h21,     1,0,1,0,0,0,0);
    add(1,0,0,1,0,0, 2,'h22,     1,0,0,1,1,'h21,1);
    add(1,0,0,1,0,0, 2,'h22,     1,0,0,1,1,'h21,1);
    add(1,0,0,1,0,1, 2,'h22,     1,0,1,1,1,'h21,1);
    add(1,0,0,1,0,1, 3,'h23,     1,0,1,1,2,'h22,1);
    add(1,0,0,0,0,1, 0,0,        1,0,1,1,3,'h23,1);
    add(1,0,0,0,0,1, 0,0,        1,0,1,0,0,0,0);
    // rdy=0 freezes the held entry (flush also ignored), then pop resumes.
    add(1,0,0,1,0,0, 1,'h31,     1,0,1,0,0,0,0);
    add(1,0,0,1,0,0, 2,'h32,     1,0,0,1,1,'h31,1);
    add(0,0,0,1,0,1, 2,'h32,     1,1,0,0,1,'h31,1);
    add(0,0,0,1,0,1, 2,'h32,     1,1,0,0,1,'h31,1);
    add(0,0,1,1,0,1, 2,'h32,     1,1,0,0,1,'h31,1);
    add(1,0,0,0,0,1, 0,0,        1,0,1,1,1,'h31,1);
    add(1,0,0,0,0,1, 0,0,        1,0,1,0,0,0,0);
`endif
    // Flush with an acceptable offer: offer is dropped, outputs cleared.
    add(1,0,0,1,0,0, 6,'h44,     1,0,1,0,0,0,0);
    add(1,0,1,1,0,1, 7,'h45,     1,0,1,1,6,'h44,1);
    add(1,0,0,0,0,1, 0,0,        1,1,1,0,0,0,0);
    // Reset while rdy=0 discards the held entry.
    add(1,0,0,1,0,0, 1,'h51,     1,0,1,0,0,0,0);
    add(0,1,0,1,0,1, 2,'h52,     1,1,0,0,1,'h51,1);
    add(1,0,0,0,0,1, 0,0,        1,1,1,0,0,0,0);
    add(1,0,0,0,0,1, 0,0,        1,0,1,0,0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rdy = vecs[i].rdy; rst = vecs[i].rst; flush = vecs[i].flush;
      in_valid = vecs[i].iv; in_bubble = vecs[i].bub; out_ready = vecs[i].ordy;
      drive(vecs[i].op, vecs[i].data);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
        check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
        check($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
        if (vecs[i].e_ov || vecs[i].chk_d)
          check_payload($sformatf("v%0d", i), vecs[i].e_op, vecs[i].e_data);
      end
      $display("vec %0d rdy=%b rst=%b flush=%b iv=%b ordy=%b op=%0d | in_ready=%b out_valid=%b out_op=%0d out_rd_data=%h occ=%0d",
               i, rdy, rst, flush, in_valid, out_ready, in_op, in_ready, out_valid, out_op, out_rd_data, occupancy);
    end

    // Randomized handshake stress against an in-order queue model, then drain.
    for (int c = 0; c < 306; c++) begin
      @(negedge clk);
      rst = 1'b0; flush = 1'b0;
      if (c < 300) begin
        rdy       = ($urandom_range(0, 7) != 0);
        in_valid  = $urandom_range(0, 1) != 0;
        out_ready = ($urandom_range(0, 2) != 0);
        in_bubble = ($urandom_range(0, 5) == 0);
        drive(6'($urandom_range(1, 63)), $urandom);
      end else begin
        rdy = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_bubble = 1'b0;
      end
      #1;
      exp_ir = rdy && (BUF ? (model_q.size() < 2) : (model_q.size() == 0 || out_ready));
      exp_ov = rdy && (model_q.size() != 0);
      check("stress_in_ready", 32'(in_ready), 32'(exp_ir));
      check("stress_out_valid", 32'(out_valid), 32'(exp_ov));
      check("stress_occupancy", 32'(occupancy), 32'(model_q.size()));
      if (exp_ov && out_ready) begin
        e = model_q.pop_front();
        check_payload("stress_pop", e.op, e.data);
        $display("pop  cycle %0d op=%0d rd_data=%h (expected op=%0d rd_data=%h)",
                 c, out_op, out_rd_data, e.op, e.data);
      end
      if (rdy && in_valid && exp_ir) begin
        e.op   = in_bubble ? 6'd0 : in_op;
        e.data = in_rd_data;
        model_q.push_back(e);
        $display("push cycle %0d op=%0d bubble=%b rd_data=%h", c, in_op, in_bubble, in_rd_data);
      end
    end

    @(negedge clk);
    #1;
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_occupancy", 32'(occupancy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
